// File: rtl/alu_bitserial_seq.sv
// Sequenced bit-serial 4-bit ALU stage: one command in, LSB-first computation,
// result and flags out, with mux select lines held for the whole operation.
module alu_bitserial_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             s0,
    output logic             s1,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_sh, a_sh_nxt;
    logic [WIDTH-1:0]  b_sh, b_sh_nxt;
    logic [1:0]        op_q, op_q_nxt;
    logic              carry, carry_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [WIDTH-1:0]  result_nxt;
    logic              cout_nxt, zero_nxt;
    logic              in_ready_nxt, busy_nxt, out_valid_nxt;
    logic              a_i, b_i, sum_i, maj_i, r_i;

    assign s0 = op_q[0];
    assign s1 = op_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            op_q      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            cout      <= 1'b0;
            zero      <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            a_sh      <= a_sh_nxt;
            b_sh      <= b_sh_nxt;
            op_q      <= op_q_nxt;
            carry     <= carry_nxt;
            cnt       <= cnt_nxt;
            result    <= result_nxt;
            cout      <= cout_nxt;
            zero      <= zero_nxt;
            in_ready  <= in_ready_nxt;
            busy      <= busy_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    // One-bit slice of the serial datapath; SUB inverts b and relies on carry-in 1
    always_comb begin
        a_i   = a_sh[0];
        b_i   = b_sh[0] ^ (op_q == OP_SUB);
        sum_i = a_i ^ b_i ^ carry;
        maj_i = (a_i & b_i) | (a_i & carry) | (b_i & carry);
        case (op_q)
            OP_AND:  r_i = a_i & b_i;
            OP_OR:   r_i = a_i | b_i;
            default: r_i = sum_i;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        a_sh_nxt   = a_sh;
        b_sh_nxt   = b_sh;
        op_q_nxt   = op_q;
        carry_nxt  = carry;
        cnt_nxt    = cnt;
        result_nxt = result;
        cout_nxt   = cout;
        zero_nxt   = zero;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_sh_nxt  = a;
                    b_sh_nxt  = b;
                    op_q_nxt  = op;
                    carry_nxt = (op == OP_SUB);
                    cnt_nxt   = '0;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                a_sh_nxt   = a_sh >> 1;
                b_sh_nxt   = b_sh >> 1;
                carry_nxt  = maj_i;
                result_nxt = {r_i, result[WIDTH-1:1]};
                cnt_nxt    = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    cout_nxt  = op_q[1] & maj_i;
                    zero_nxt  = (result_nxt == '0);
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        in_ready_nxt  = (state_nxt == IDLE);
        busy_nxt      = (state_nxt != IDLE);
        out_valid_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Directed self-checking bench for alu_bitserial_seq (WIDTH=4).
module tb_alu_bitserial_seq;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             s0, s1, busy, out_valid, out_ready, cout, zero;
    logic [WIDTH-1:0] result;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    alu_bitserial_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .s0(s0), .s1(s1), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .cout(cout), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and return one step after the accepting edge
    task automatic send(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int g;
        g = 0;
        in_valid = 1'b1; op = o; a = x; b = y;
        while (!in_ready && g < 100) begin tick(); g++; end
        chk("send_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges from accept until out_valid, checking the select lines hold
    task automatic wait_done(input logic [1:0] o);
        int lat;
        lat = 0;
        while (!out_valid && lat < 50) begin
            chk("sel_calc", 32'({s1, s0}), 32'(o));
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(WIDTH));
        chk("sel_done", 32'({s1, s0}), 32'(o));
        chk("busy_done", 32'(busy), 32'd1);
    endtask

    task automatic take(input logic [WIDTH-1:0] r, input logic c, input logic z);
        chk("result", 32'(result), 32'(r));
        chk("cout", 32'(cout), 32'(c));
        chk("zero", 32'(zero), 32'(z));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ov_drop", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int t[3];
        int g;
        logic [WIDTH-1:0] ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'b00; a = '0; b = '0;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sel", 32'({s1, s0}), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({cout, zero}), 32'd0);
        rst_n = 1'b1;
        tick();

        send(2'b10, 4'd9, 4'd8);  wait_done(2'b10); take(4'd1, 1'b1, 1'b0);
        send(2'b11, 4'd3, 4'd5);  wait_done(2'b11); take(4'hE, 1'b0, 1'b0);
        send(2'b11, 4'd5, 4'd5);  wait_done(2'b11); take(4'h0, 1'b1, 1'b1);
        send(2'b00, 4'hC, 4'hA);  wait_done(2'b00); take(4'h8, 1'b0, 1'b0);
        send(2'b01, 4'hC, 4'hA);  wait_done(2'b01); take(4'hE, 1'b0, 1'b0);
        chk("sel_hold_idle", 32'({s1, s0}), 32'd1);

        // Backpressure: DONE held with a competing command on the inputs
        send(2'b10, 4'd2, 4'd3);  wait_done(2'b10);
        in_valid = 1'b1; op = 2'b00; a = 4'hF; b = 4'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_result", 32'({result, cout, zero}), 32'({4'd5, 1'b0, 1'b0}));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_sel", 32'({s1, s0}), 32'd2);
        end
        in_valid = 1'b0;
        take(4'd5, 1'b0, 1'b0);
        chk("bp_no_accept", 32'(busy), 32'd0);

        // Reset while processing bit 2 of ADD 7+7
        send(2'b10, 4'd7, 4'd7);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 32'({in_ready, busy, out_valid, s1, s0, cout, zero}), 32'b1000000);
        chk("mid_rst_result", 32'(result), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < WIDTH + 3; i++) begin
            tick();
            chk("mid_rst_no_ov", 32'(out_valid), 32'd0);
        end
        send(2'b10, 4'd1, 4'd1);  wait_done(2'b10); take(4'd2, 1'b0, 1'b0);

        // Back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = 2'b10;
        for (int k = 0; k < 3; k++) begin
            ra = (k == 0) ? 4'd1 : (k == 1) ? 4'd15 : 4'd6;
            rb = (k == 0) ? 4'd2 : (k == 1) ? 4'd1  : 4'd6;
            a = ra; b = rb;
            g = 0;
            while (!in_ready && g < 50) begin tick(); g++; end
            chk("b2b_ready", 32'(in_ready), 32'd1);
            tick();
            t[k] = cyc;
            g = 0;
            while (!out_valid && g < 50) begin tick(); g++; end
            chk("b2b_result", 32'({cout, result}), 32'(5'(ra) + 5'(rb)));
        end
        in_valid = 1'b0;
        chk("b2b_gap1", 32'(t[1] - t[0]), 32'(WIDTH + 2));
        chk("b2b_gap2", 32'(t[2] - t[1]), 32'(WIDTH + 2));
        tick();
        out_ready = 1'b0;
        chk("b2b_idle", 32'(in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
